// File: rtl/seq_pipe_pkg.sv
// Shared types and constants for the two-entry skid buffer
// in front of the single-stage pipe delay.
package seq_pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

  localparam int SKID_DEPTH = 2;

  // Number of held entries for a given buffer state.
  function automatic logic [1:0] occ_of(input skid_state_t s);
    case (s)
      EMPTY:   return 2'd0;
      ONE:     return 2'd1;
      TWO:     return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/seq_pipe_skid_buffer_if.sv
// Valid/ready handshake bundle between producer, skid buffer and consumer.
// The slave modport is the buffer's view; master is the environment's view.
interface seq_pipe_skid_buffer_if #(
  parameter int NBITS = 8
);

  logic             in_val;
  logic             in_rdy;
  logic [NBITS-1:0] in_msg;
  logic             out_val;
  logic             out_rdy;
  logic [NBITS-1:0] out_msg;
  logic [1:0]       occupancy;

  modport slave (
    input  in_val,
    input  in_msg,
    input  out_rdy,
    output in_rdy,
    output out_val,
    output out_msg,
    output occupancy
  );

  modport master (
    output in_val,
    output in_msg,
    output out_rdy,
    input  in_rdy,
    input  out_val,
    input  out_msg,
    input  occupancy
  );

endinterface

// File: rtl/seq_pipe_en_reg.sv
// NBITS-wide data register with load enable and asynchronous active-low clear.
module seq_pipe_en_reg #(
  parameter int NBITS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [NBITS-1:0] d,
  output logic [NBITS-1:0] q
);

  // Enable-gated load; contents are held whenever en is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= {NBITS{1'b0}};
    end else if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/seq_pipe_skid_buffer.sv
// Two-entry valid/ready skid buffer; handshake outputs come straight from
// flops so out_rdy never reaches in_rdy combinationally.
module seq_pipe_skid_buffer
  import seq_pipe_pkg::*;
#(
  parameter int NBITS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  seq_pipe_skid_buffer_if.slave bus
);

  skid_state_t      state_r;
  skid_state_t      state_s;
  logic             out_val_r;
  logic             in_rdy_r;
  logic [1:0]       occ_r;
  logic             enq_s;
  logic             deq_s;
  logic             load_main_s;
  logic             load_skid_s;
  logic             main_from_skid_s;
  logic [NBITS-1:0] main_d_s;
  logic [NBITS-1:0] main_q_s;
  logic [NBITS-1:0] skid_q_s;

  assign enq_s = bus.in_val & in_rdy_r;
  assign deq_s = out_val_r & bus.out_rdy;

  // Next-state and register-enable decode.
  always_comb begin
    state_s          = state_r;
    load_main_s      = 1'b0;
    load_skid_s      = 1'b0;
    main_from_skid_s = 1'b0;
    case (state_r)
      EMPTY: begin
        if (enq_s) begin
          load_main_s = 1'b1;
          state_s     = ONE;
        end else begin
          state_s     = EMPTY;
        end
      end
      ONE: begin
        if (enq_s && deq_s) begin
          load_main_s = 1'b1;
          state_s     = ONE;
        end else if (enq_s) begin
          load_skid_s = 1'b1;
          state_s     = TWO;
        end else if (deq_s) begin
          state_s     = EMPTY;
        end else begin
          state_s     = ONE;
        end
      end
      TWO: begin
        if (deq_s) begin
          load_main_s      = 1'b1;
          main_from_skid_s = 1'b1;
          state_s          = ONE;
        end else begin
          state_s          = TWO;
        end
      end
      default: begin
        state_s = EMPTY;
      end
    endcase
  end

  // Head entry refills from the skid entry when draining out of TWO.
  always_comb begin
    if (main_from_skid_s) begin
      main_d_s = skid_q_s;
    end else begin
      main_d_s = bus.in_msg;
    end
  end

  // State register with handshake outputs registered alongside it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= EMPTY;
      out_val_r <= 1'b0;
      in_rdy_r  <= 1'b1;
      occ_r     <= 2'd0;
    end else begin
      state_r   <= state_s;
      out_val_r <= (state_s != EMPTY);
      in_rdy_r  <= (occ_of(state_s) != 2'(SKID_DEPTH));
      occ_r     <= occ_of(state_s);
    end
  end

  seq_pipe_en_reg #(.NBITS(NBITS)) main_reg (
    .clk   (clk),
    .reset (reset),
    .en    (load_main_s),
    .d     (main_d_s),
    .q     (main_q_s)
  );

  seq_pipe_en_reg #(.NBITS(NBITS)) skid_reg (
    .clk   (clk),
    .reset (reset),
    .en    (load_skid_s),
    .d     (bus.in_msg),
    .q     (skid_q_s)
  );

  assign bus.out_val   = out_val_r;
  assign bus.in_rdy    = in_rdy_r;
  assign bus.occupancy = occ_r;
  assign bus.out_msg   = main_q_s;

endmodule
